m92_sound_latch: RTL and testbench

M92_SOUND_LATCH -- requirements
Module: m92_sound_latch

---
 rtl/m92_sound_latch_if.sv | 40 ++++
 rtl/m92_sound_latch.sv | 153 +++++++++++++++
 tb/tb_m92_sound_latch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/m92_sound_latch_if.sv
// Command/reply bus between the main CPU, the sound CPU and the sound latch.
// Signals:
//   main_wr/main_din   command write from the main CPU (IO 0x00)
//   main_rd            reply read strobe from the main CPU (IO 0x08)
//   main_dout/main_irq reply latch contents / reply pending level
//   snd_rd/snd_dout    command pop strobe / FIFO head (0xFF when empty)
//   snd_wr/snd_din     reply write from the sound CPU
//   snd_ack/snd_irq    IRQ acknowledge / command-available interrupt
//   cmd_count          FIFO occupancy
//   overflow           sticky flag: a command byte was dropped
// Modports: master = CPU side (drives strobes), slave = the latch.
interface m92_sound_latch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          main_wr;
  logic [7:0]    main_din;
  logic          main_rd;
  logic [7:0]    main_dout;
  logic          main_irq;
  logic          snd_rd;
  logic [7:0]    snd_dout;
  logic          snd_wr;
  logic [7:0]    snd_din;
  logic          snd_ack;
  logic          snd_irq;
  logic [CW-1:0] cmd_count;
  logic          overflow;

  modport master (
    output main_wr, main_din, main_rd, snd_rd, snd_wr, snd_din, snd_ack,
    input  main_dout, main_irq, snd_dout, snd_irq, cmd_count, overflow
  );

  modport slave (
    input  main_wr, main_din, main_rd, snd_rd, snd_wr, snd_din, snd_ack,
    output main_dout, main_irq, snd_dout, snd_irq, cmd_count, overflow
  );
endinterface

// File: rtl/m92_sound_latch.sv
// M92 sound latch: main-to-sound command FIFO with a rate-limited
// command-available interrupt, and a single-byte sound-to-main reply latch.
// Ports:
//   clk    system clock (CLK_32M), rising edge
//   reset  asynchronous, active-high
//   bus    m92_sound_latch_if.slave (see interface header for signals)
// Parameters:
//   DEPTH   command FIFO depth, power of two, 2..16
//   HOLDOFF cycles after snd_ack before snd_irq may re-assert, 1..255
module m92_sound_latch #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  m92_sound_latch_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  irq_state_t    state;
  logic [7:0]    hold_cnt;
  logic          irq_q;

  logic [7:0]    reply;
  logic          reply_pending;

  // Full/empty come from the occupancy count alone; pointers are free to
  // alias when full. A pop on a full FIFO frees the head slot in the same
  // edge, so the simultaneous push is accepted rather than dropped.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    pop   = bus.snd_rd && !empty;
    push  = bus.main_wr && (!full || bus.snd_rd);
    drop  = bus.main_wr && full && !bus.snd_rd;
  end

  // Storage has no reset; stale entries are never visible because the
  // head is masked to 0xFF whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.main_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Interrupt sequencer. Draining the FIFO does not cancel an asserted
  // interrupt; only snd_ack does, followed by a HOLDOFF-cycle quiet period
  // and one IDLE cycle in which the registered count is re-examined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= ASSERT;
            irq_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (bus.snd_ack) begin
            state    <= HOLD;
            hold_cnt <= 8'(HOLDOFF);
            irq_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt <= 8'd1) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          irq_q    <= 1'b0;
        end
      endcase
    end
  end

  // Reply latch: a write in the same cycle as a read wins, so the new
  // byte is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reply         <= '1;
      reply_pending <= 1'b0;
    end else begin
      if (bus.snd_wr) begin
        reply         <= bus.snd_din;
        reply_pending <= 1'b1;
      end else if (bus.main_rd) begin
        reply_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.snd_dout  = empty ? 8'hFF : mem[rptr];
    bus.snd_irq   = irq_q;
    bus.cmd_count = count;
    bus.overflow  = ovf;
    bus.main_dout = reply;
    bus.main_irq  = reply_pending;
  end
endmodule

// File: tb/tb_m92_sound_latch.sv
module tb_m92_sound_latch;
  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  m92_sound_latch_if #(.DEPTH(DEPTH)) bus ();

  m92_sound_latch #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    int dout;
    int ovf;
    int irq;
    int pend;
    int latch;
  } snap_t;

  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: byte queue for the FIFO, timestamps for the IRQ.
  logic [7:0] mq[$];
  int m_ovf, m_pend, m_latch, m_irq;
  int hold_end;
  int cyc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_ovf    = 0;
    m_pend   = 0;
    m_latch  = 8'hFF;
    m_irq    = 0;
    hold_end = -1;
  endfunction

  function automatic void push_snap();
    snap_t s;
    s.cnt   = mq.size();
    s.dout  = (mq.size() > 0) ? int'(mq[0]) : 8'hFF;
    s.ovf   = m_ovf;
    s.irq   = m_irq;
    s.pend  = m_pend;
    s.latch = m_latch;
    exp_q.push_back(s);
  endfunction

  function automatic void model_edge(bit wr, logic [7:0] din, bit rd, bit swr,
                                     logic [7:0] sdin, bit ack, bit mrd);
    int sz = mq.size();
    // IRQ: after an ack in cycle c, cycles c+1..c+HOLDOFF are quiet; a
    // cycle past that looks at the occupancy visible during that cycle.
    if (m_irq != 0) begin
      if (ack) begin
        m_irq    = 0;
        hold_end = cyc + HOLDOFF;
      end
    end else if (cyc > hold_end) begin
      m_irq = (sz > 0) ? 1 : 0;
    end
    if (wr && sz == DEPTH && !rd) m_ovf = 1;
    if (rd && sz > 0) void'(mq.pop_front());
    if (wr && (sz < DEPTH || rd)) mq.push_back(din);
    if (swr) begin
      m_latch = int'(sdin);
      m_pend  = 1;
    end else if (mrd) begin
      m_pend = 0;
    end
    cyc++;
  endfunction

  task automatic step(input bit wr, input logic [7:0] din, input bit rd,
                      input bit swr, input logic [7:0] sdin, input bit ack,
                      input bit mrd);
    bus.main_wr  = wr;
    bus.main_din = din;
    bus.snd_rd   = rd;
    bus.snd_wr   = swr;
    bus.snd_din  = sdin;
    bus.snd_ack  = ack;
    bus.main_rd  = mrd;
    model_edge(wr, din, rd, swr, sdin, ack, mrd);
    @(posedge clk);
    #1;
    push_snap();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic wr_cmd(input logic [7:0] b);
    step(1, b, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic rd_cmd();
    step(0, 8'h00, 1, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    bus.main_wr = 0; bus.main_din = '0; bus.snd_rd = 0; bus.snd_wr = 0;
    bus.snd_din = '0; bus.snd_ack = 0; bus.main_rd = 0;
    reset = 1'b1;
    #1;
    chk("rst_cmd_count", 32'(bus.cmd_count), 0);
    chk("rst_snd_irq",   32'(bus.snd_irq), 0);
    chk("rst_snd_dout",  32'(bus.snd_dout), 8'hFF);
    chk("rst_main_dout", 32'(bus.main_dout), 8'hFF);
    chk("rst_main_irq",  32'(bus.main_irq), 0);
    model_clear();
    push_snap();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every snapshot the stimulus side queued.
  always @(negedge clk) begin : mon
    snap_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cmd_count", 32'(bus.cmd_count), e.cnt);
      chk("snd_dout",  32'(bus.snd_dout),  e.dout);
      chk("overflow",  32'(bus.overflow),  e.ovf);
      chk("snd_irq",   32'(bus.snd_irq),   e.irq);
      chk("main_irq",  32'(bus.main_irq),  e.pend);
      chk("main_dout", 32'(bus.main_dout), e.latch);
    end
  end

  initial begin : stim
    int low;
    int guard;
    cyc = 0;
    model_clear();
    bus.main_wr = 0; bus.main_din = '0; bus.snd_rd = 0; bus.snd_wr = 0;
    bus.snd_din = '0; bus.snd_ack = 0; bus.main_rd = 0;
    do_reset();

    // Two commands, then one pop.
    wr_cmd(8'h12);
    wr_cmd(8'h34);
    chk("two_wr_head", 32'(bus.snd_dout), 8'h12);
    chk("two_wr_irq",  32'(bus.snd_irq), 1);
    rd_cmd();
    chk("pop_head", 32'(bus.snd_dout), 8'h34);
    chk("pop_count", 32'(bus.cmd_count), 1);
    rd_cmd();
    rd_cmd();   // pop on empty is ignored

    // Overflow on the fifth byte, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) wr_cmd(8'(8'hA0 + i));
    chk("ovf_flag", 32'(bus.overflow), 1);
    for (int i = 0; i < 5; i++) rd_cmd();

    // Full FIFO with push and pop together.
    do_reset();
    for (int i = 0; i < 4; i++) wr_cmd(8'(8'hB0 + i));
    step(1, 8'h55, 1, 0, 8'h00, 0, 0);
    chk("full_pp_count", 32'(bus.cmd_count), 4);
    chk("full_pp_ovf",   32'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) rd_cmd();
    // Push and pop together on an empty FIFO.
    step(1, 8'h66, 1, 0, 8'h00, 0, 0);
    chk("empty_pp_count", 32'(bus.cmd_count), 1);
    rd_cmd();

    // IRQ holdoff after acknowledge.
    do_reset();
    wr_cmd(8'h01);
    wr_cmd(8'h02);
    step(0, 8'h00, 0, 0, 8'h00, 1, 0);
    low = 0;
    while (bus.snd_irq === 1'b0 && low < 100) begin
      low++;
      idle(1);
    end
    chk("holdoff_low_cycles", low, HOLDOFF + 1);
    step(0, 8'h00, 0, 0, 8'h00, 1, 0);
    rd_cmd(); rd_cmd();
    idle(HOLDOFF + 4);

    // Reply latch.
    step(0, 8'h00, 0, 1, 8'h9C, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1);
    chk("reply_retained", 32'(bus.main_dout), 8'h9C);
    step(0, 8'h00, 0, 1, 8'h3E, 0, 1);
    chk("reply_wr_rd", 32'(bus.main_irq), 1);

    // Reset with three bytes queued and the IRQ up.
    wr_cmd(8'h70); wr_cmd(8'h71); wr_cmd(8'h72);
    idle(2);
    do_reset();
    wr_cmd(8'h44);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 300; i++) begin
        step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0,
             ($urandom % 8) == 0, 8'($urandom), ($urandom % 5) == 0,
             ($urandom % 6) == 0);
      end
      do_reset();
    end
    idle(3);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
